ctle_rx_monitor: RTL

- Receive-side checker for the CTLE emulation path.
- Samples the signed fixed-point CTLE output once per emulation step and slices it to a bit with hysteresis.
- Measures high and low run lengths, checks them against the expected square-wave half-period, and flags lock and errors.
- Sits after the CTLE so benches and FPGA emulation can confirm the equalized PWM stimulus is recovered intact.

---
 rtl/ctle_rx_monitor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ctle_rx_monitor.sv
// Receive-side checker for the CTLE emulation path: hysteresis slicer, run-length
// measurement against the expected square-wave half-period, lock and error tracking.
module ctle_rx_monitor #(
  parameter int WIDTH    = 16,
  parameter int TH_HI    = 256,
  parameter int TH_LO    = -256,
  parameter int CNT_W    = 12,
  parameter int EXP_HALF = 5,
  parameter int TOL      = 1,
  parameter int LOCK_N   = 4
) (
  input  logic             emu_clk,
  input  logic             emu_rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] v_in,
  output logic             bit_out,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int GOOD_LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
  localparam logic signed [WIDTH-1:0] TH_HI_S = WIDTH'(TH_HI);
  localparam logic signed [WIDTH-1:0] TH_LO_S = WIDTH'(TH_LO);
  localparam logic [CNT_W-1:0] GOOD_LO = CNT_W'(GOOD_LO_I);
  localparam logic [CNT_W-1:0] GOOD_HI = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(2 * EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_N);

  typedef enum logic [1:0] {SEARCH, ARMED, MEASURE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             bit_q, bit_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [GW-1:0]    good_q, good_d;

  logic signed [WIDTH-1:0] v_s;
  logic             nbit;
  logic             trans;
  logic             run_good;
  logic             timeout;
  logic [CNT_W-1:0] run_inc;
  logic [GW-1:0]    good_inc;
  logic [7:0]       err_inc;

  assign v_s      = v_in;
  assign nbit     = (v_s >= TH_HI_S) ? 1'b1 : ((v_s <= TH_LO_S) ? 1'b0 : bit_q);
  assign trans    = en && (nbit != bit_q);
  assign run_good = (run_q >= GOOD_LO) && (run_q <= GOOD_HI);
  assign run_inc  = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
  assign good_inc = (good_q == LOCK_V) ? good_q : good_q + 1'b1;
  assign err_inc  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  // A transition in the same step always overrides the timeout.
  assign timeout  = en && !trans && (state_q != SEARCH) && (run_inc > TO_LIM);

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q      <= SEARCH;
      bit_q        <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_cnt_q    <= '0;
      run_q        <= '0;
      good_q       <= '0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_cnt_q    <= err_cnt_d;
      run_q        <= run_d;
      good_q       <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (trans) begin
      case (state_q)
        SEARCH:  state_d = ARMED;
        LOCKED:  state_d = run_good ? LOCKED : MEASURE;
        default: state_d = (run_good && (good_inc == LOCK_V)) ? LOCKED : MEASURE;
      endcase
    end else if (timeout) begin
      state_d = SEARCH;
    end
  end

  always_comb begin
    bit_d        = bit_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    meas_valid_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    run_d        = run_q;
    good_d       = good_q;
    locked_d     = (state_d == LOCKED);
    if (en) begin
      bit_d = nbit;
      if (trans) begin
        run_d = {{(CNT_W-1){1'b0}}, 1'b1};
        if (nbit) begin
          rise_d       = 1'b1;
          low_cnt_d    = run_q;
          meas_valid_d = (state_q == MEASURE) || (state_q == LOCKED);
        end else begin
          fall_d     = 1'b1;
          high_cnt_d = run_q;
        end
        // The run that ends while searching started mid-way, so it is never judged.
        if (state_q != SEARCH) begin
          if (run_good) begin
            good_d = good_inc;
          end else begin
            good_d    = '0;
            err_cnt_d = err_inc;
          end
        end
      end else begin
        run_d = run_inc;
        if (timeout) begin
          err_cnt_d = err_inc;
          good_d    = '0;
        end
      end
    end
  end

  assign bit_out    = bit_q;
  assign edge_rise  = rise_q;
  assign edge_fall  = fall_q;
  assign high_cnt   = high_cnt_q;
  assign low_cnt    = low_cnt_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err_cnt    = err_cnt_q;

endmodule
